// File: rtl/natv_axil_pkg.sv
// rtl/natv_axil_pkg.sv - shared state encoding and AXI protection constants for the native-to-AXI-lite bridge
package natv_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  function automatic logic [2:0] axi_prot(input logic instr);
    return instr ? PROT_INSTR : PROT_DATA;
  endfunction

endpackage

// File: rtl/natv_axil_bridge.sv
// rtl/natv_axil_bridge.sv - CPU native memory port to AXI-lite master bridge with forced completion on timeout
module natv_axil_bridge
  import natv_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               arvalid_q, arvalid_d;
  logic               bready_q, bready_d;
  logic               rready_q, rready_d;
  logic               mem_ready_q, mem_ready_d;
  logic               timeout_q, timeout_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [2:0]         prot_q, prot_d;

  logic aw_left, w_left, ar_left, b_hs, r_hs, expire;

  // A valid still pending after this edge is one that was not handshaken this cycle.
  assign aw_left = awvalid_q && !mem_axi_awready;
  assign w_left  = wvalid_q && !mem_axi_wready;
  assign ar_left = arvalid_q && !mem_axi_arready;
  assign b_hs    = bready_q && mem_axi_bvalid;
  assign r_hs    = rready_q && mem_axi_rvalid;
  assign expire  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      mem_ready_q <= mem_ready_d;
      timeout_q   <= timeout_d;
      is_wr_q     <= is_wr_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    mem_ready_d = 1'b0;
    timeout_d   = 1'b0;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;

    if (state_q != ST_IDLE && state_q != ST_DRAIN) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // mem_ready_q blocks re-accepting the request that was just completed.
        if (mem_valid && !mem_ready_q) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          prot_d  = axi_prot(mem_instr);
          cnt_d   = CNT_W'(1);
          if (mem_wstrb != 4'b0000) begin
            state_d   = ST_WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            is_wr_d   = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
            is_wr_d   = 1'b0;
          end
        end
      end

      ST_WR_ADDR: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (expire) begin
          mem_ready_d = 1'b1;
          timeout_d   = 1'b1;
          bready_d    = 1'b1;
          state_d     = ST_DRAIN;
        end else if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          mem_ready_d = 1'b1;
          bready_d    = 1'b0;
          state_d     = ST_IDLE;
        end else if (expire) begin
          mem_ready_d = 1'b1;
          timeout_d   = 1'b1;
          state_d     = ST_DRAIN;
        end
      end

      ST_RD_ADDR: begin
        arvalid_d = ar_left;
        if (expire) begin
          mem_ready_d = 1'b1;
          timeout_d   = 1'b1;
          rdata_d     = ERR_RDATA;
          rready_d    = 1'b1;
          state_d     = ST_DRAIN;
        end else if (!ar_left) begin
          rready_d = 1'b1;
          state_d  = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (r_hs) begin
          rdata_d     = mem_axi_rdata;
          mem_ready_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = ST_IDLE;
        end else if (expire) begin
          mem_ready_d = 1'b1;
          timeout_d   = 1'b1;
          rdata_d     = ERR_RDATA;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The CPU already saw completion; finish the AXI transaction and drop its response.
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        arvalid_d = ar_left;
        if (is_wr_q ? b_hs : r_hs) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = rdata_q;
  assign timeout_o       = timeout_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = prot_q;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = prot_q;
  assign mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_natv_axil_bridge.sv
// tb/tb_natv_axil_bridge.sv - self-checking bench for natv_axil_bridge: vector table, reset corner, randomized traffic
module tb_natv_axil_bridge;

  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk, rst_i;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, timeout_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  natv_axil_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic        wr;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          a_d;
    int          w_d;
    int          r_d;
    logic        force_rd;
    logic [31:0] rdata;
    int          exp_lat;
    logic        exp_to;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
  endtask

  // One CPU request against a small AXI slave whose ready/response timing comes from the vector.
  task automatic run_txn(input vec_t v, input string tag);
    int cyc, lat, viol, first_v, aw_cyc, w_cyc, ar_cyc, resp_cyc, last_a;
    bit aw_hs, w_hs, ar_hs, resp_done, seen_rdy, got_to;
    logic [31:0] cap_addr, cap_wdata, rd;
    logic [2:0]  cap_prot;
    logic [3:0]  cap_strb;
    cyc = 0; lat = -1; viol = 0; first_v = -1; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; resp_cyc = -1;
    aw_hs = 0; w_hs = 0; ar_hs = 0; resp_done = 0; seen_rdy = 0; got_to = 0;
    cap_addr = 'x; cap_wdata = 'x; cap_prot = 'x; cap_strb = 'x; rd = 'x;
    if (v.wr) model_mem[v.addr] = merge(model_read(v.addr), v.wdata, v.wstrb);
    mem_valid = 1'b1;
    mem_instr = v.instr;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wr ? v.wstrb : 4'b0000;
    while (cyc < 60 && !(seen_rdy && resp_done && cyc > resp_cyc)) begin
      @(posedge clk); #1;
      cyc++;
      if (timeout_o && !mem_ready) viol++;
      if (mem_ready) begin
        if (seen_rdy) viol++;
        else begin
          seen_rdy = 1; lat = cyc; rd = mem_rdata; got_to = timeout_o;
          mem_valid = 1'b0;
        end
      end else if (seen_rdy && mem_rdata !== rd) viol++;
      if (first_v < 0 && (awvalid || wvalid || arvalid)) first_v = cyc;
      if (aw_hs && awvalid) viol++;
      if (w_hs && wvalid) viol++;
      if (ar_hs && arvalid) viol++;
      awready = v.wr && cyc >= 1 + v.a_d;
      wready  = v.wr && cyc >= 1 + v.w_d;
      arready = !v.wr && cyc >= 1 + v.a_d;
      if (awvalid && awready && !aw_hs) begin
        aw_hs = 1; aw_cyc = cyc; cap_addr = awaddr; cap_prot = awprot;
      end
      if (wvalid && wready && !w_hs) begin
        w_hs = 1; w_cyc = cyc; cap_wdata = wdata; cap_strb = wstrb;
      end
      if (arvalid && arready && !ar_hs) begin
        ar_hs = 1; ar_cyc = cyc; cap_addr = araddr; cap_prot = arprot;
      end
      bvalid = 1'b0;
      rvalid = 1'b0;
      last_a = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
      if (!resp_done && v.wr && aw_hs && w_hs && cyc >= last_a + 1 + v.r_d) begin
        bvalid = 1'b1;
        if (bready) begin
          resp_done = 1; resp_cyc = cyc;
          slave_mem[cap_addr] = merge(slave_read(cap_addr), cap_wdata, cap_strb);
        end
      end
      if (!resp_done && !v.wr && ar_hs && cyc >= ar_cyc + 1 + v.r_d) begin
        rvalid = 1'b1;
        rdata  = v.force_rd ? v.rdata : slave_read(cap_addr);
        if (rready) begin
          resp_done = 1; resp_cyc = cyc;
        end
      end
    end
    if (cyc >= 60) chk({tag, ".bound"}, 64'(cyc), 64'(0));
    clear_slave();
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".lat"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, ".timeout"}, 64'(got_to), 64'(v.exp_to));
    chk({tag, ".rdata"}, 64'(rd), 64'(v.exp_rdata));
    chk({tag, ".valid_cyc"}, 64'(first_v), 64'(1));
    chk({tag, ".addr"}, 64'(cap_addr), 64'(v.addr));
    chk({tag, ".prot"}, 64'(cap_prot), 64'({v.instr, 2'b00}));
    if (v.wr) begin
      chk({tag, ".wdata"}, 64'(cap_wdata), 64'(v.wdata));
      chk({tag, ".wstrb"}, 64'(cap_strb), 64'(v.wstrb));
    end
    chk({tag, ".protocol"}, 64'(viol), 64'(0));
    last_rdata = v.exp_rdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, 64'({awvalid, wvalid, arvalid, bready, rready, mem_ready, timeout_o}), 64'(0));
    chk({tag, ".rdata"}, 64'(mem_rdata), 64'(0));
    chk({tag, ".addr"}, 64'({awaddr, araddr}), 64'(0));
    chk({tag, ".data"}, 64'({wdata, wstrb, awprot, arprot}), 64'(0));
  endtask

  vec_t tbl [8];
  vec_t v;

  initial begin
    int n, cnt;
    // wr instr addr wdata wstrb a_d w_d r_d force rdata exp_lat exp_to exp_rdata
    tbl[0] = '{1'b0, 1'b0, 32'h0300_3000, 32'h0, 4'h0, 0, 0, 0,  1'b1, 32'h1234_5678, 3, 1'b0, 32'h1234_5678};
    tbl[1] = '{1'b1, 1'b0, 32'h0300_4004, 32'hA5A5_A5A5, 4'b0011, 0, 3, 0, 1'b0, 32'h0, 6, 1'b0, 32'h1234_5678};
    tbl[2] = '{1'b0, 1'b1, 32'h3000_0000, 32'h0, 4'h0, 0, 0, 0,  1'b1, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D};
    tbl[3] = '{1'b1, 1'b0, 32'h0300_0008, 32'h0102_0304, 4'b1111, 2, 0, 1, 1'b0, 32'h0, 6, 1'b0, 32'hCAFE_F00D};
    tbl[4] = '{1'b0, 1'b0, 32'h0300_000C, 32'h0, 4'h0, 0, 0, 10, 1'b1, 32'h1111_1111, 8, 1'b1, 32'hFFFF_FFFF};
    tbl[5] = '{1'b0, 1'b0, 32'h0300_0010, 32'h0, 4'h0, 0, 0, 5,  1'b1, 32'h0BAD_BEEF, 8, 1'b0, 32'h0BAD_BEEF};
    tbl[6] = '{1'b1, 1'b1, 32'h0300_0014, 32'h7777_8888, 4'b1000, 11, 0, 0, 1'b0, 32'h0, 8, 1'b1, 32'h0BAD_BEEF};
    tbl[7] = '{1'b0, 1'b0, 32'h0300_0008, 32'h0, 4'h0, 1, 1, 1,  1'b0, 32'h0, 5, 1'b0, 32'h0102_0304};

    rst_i = 1'b1;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    clear_slave();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_i = 1'b0;
    last_rdata = '0;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for the write response abandons the transaction.
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0300_0020;
    mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b1111;
    awready = 1'b1; wready = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!bready && cnt < 10);
    chk("rst_wr.reach_resp", 64'(bready), 64'(1));
    rst_i = 1'b1;
    mem_valid = 1'b0;
    clear_slave();
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk_all_zero("rst_wr");
    last_rdata = '0;
    v = '{1'b0, 1'b0, 32'h0300_0024, 32'h0, 4'h0, 0, 0, 0, 1'b1, 32'h600D_F00D, 3, 1'b0, 32'h600D_F00D};
    run_txn(v, "rst_wr.read");

    // Randomized traffic; expectations from latency rules and a CPU-side memory image.
    n = 40;
    for (int i = 0; i < n; i++) begin
      int lat_n;
      v.wr       = 1'($urandom_range(0, 1));
      v.instr    = !v.wr && ($urandom_range(0, 3) == 0);
      v.addr     = 32'h0300_0000 | (32'($urandom_range(0, 7)) << 2);
      v.wdata    = $urandom;
      v.wstrb    = v.wr ? 4'($urandom_range(1, 15)) : 4'h0;
      v.a_d      = int'($urandom_range(0, 2));
      v.w_d      = int'($urandom_range(0, 2));
      v.r_d      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 9)) : int'($urandom_range(0, 2));
      v.force_rd = 1'b0;
      v.rdata    = '0;
      lat_n = v.wr ? ((v.a_d > v.w_d ? v.a_d : v.w_d) + v.r_d + 3) : (v.a_d + v.r_d + 3);
      v.exp_to    = (lat_n > TMO);
      v.exp_lat   = v.exp_to ? TMO : lat_n;
      v.exp_rdata = v.wr ? last_rdata : (v.exp_to ? ERR : model_read(v.addr));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
